// File: rtl/param_arb_pkg.sv
// Shared types and helpers for the parameter-mode arbiter and its
// round-robin picker.
package param_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OWN    = 2'd2
    } arb_state_t;

    // Bit width able to hold n distinct values, never narrower than one bit
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/param_mode_arbiter_rr_pick.sv
// Combinational round-robin selector. Starting at index ptr and searching
// upward with wrap-around, returns the first asserted request as a one-hot
// pick. found is low (and pick all zero) when no request is asserted.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic            found
);

    // Scan from ptr upward, modulo NREQ, and take the first requester
    always_comb begin
        int idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_mode_arbiter.sv
// Shares one parameter_function instance (and its single mode input) among
// NREQ requesters. Round-robin arbitration, a settle window after every
// mode change before the grant is issued, and a bounded ownership period.
//
// Handshake: req is a level held for as long as a requester wants the
// resource; gnt is a one-hot level that rises only after mode has been
// stable for SETTLE_CYC cycles; the owner ends ownership by pulsing rel or
// dropping req, otherwise the grant is withdrawn after HOLD_MAX cycles with
// a one-cycle timeout pulse. rel from non-owners is ignored.
module param_mode_arbiter
    import param_arb_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int BW_MODE      = 2,
    parameter int SETTLE_CYC   = 8,
    parameter int HOLD_MAX     = 64,
    parameter int DEFAULT_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*BW_MODE-1:0] req_mode,
    input  logic [NREQ-1:0]         rel,
    output logic [NREQ-1:0]         gnt,
    output logic [BW_MODE-1:0]      mode,
    output logic                    param_valid,
    output logic                    busy,
    output logic                    timeout,
    output logic [1:0]              state_dbg
);

    localparam int PW = clog2_min1(NREQ);
    localparam int SW = clog2_min1(SETTLE_CYC + 1);
    localparam int HW = clog2_min1(HOLD_MAX + 1);

    // Last counter value before the transition; SETTLE is unreachable when
    // SETTLE_CYC is 0, so its terminal value is irrelevant in that case.
    localparam logic [SW-1:0] SETTLE_LAST = (SETTLE_CYC > 0) ? SW'(SETTLE_CYC - 1) : '0;
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_MAX - 1);
    localparam logic [PW-1:0] PTR_LAST    = PW'(NREQ - 1);

    arb_state_t          state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [BW_MODE-1:0]  mode_q, mode_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [SW-1:0]       scnt_q, scnt_d;
    logic [HW-1:0]       hcnt_q, hcnt_d;
    logic                tmo_q, tmo_d;

    logic [NREQ-1:0]     pick;
    logic                found;
    logic [PW-1:0]       pick_idx;
    logic [BW_MODE-1:0]  pick_mode;
    logic [NREQ-1:0]     owner_onehot;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .found (found)
    );

    // Encode the one-hot pick to an index and fetch the winner's mode
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx = PW'(i);
            end
        end
        pick_mode    = req_mode[pick_idx*BW_MODE +: BW_MODE];
        owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
    end

    // Next-state, counters, mode and grant; exits from OWN rotate the pointer
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        mode_d  = mode_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        scnt_d  = scnt_q;
        hcnt_d  = hcnt_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = pick_idx;
                    if (pick_mode == mode_q || SETTLE_CYC == 0) begin
                        state_d = OWN;
                        gnt_d   = pick;
                        hcnt_d  = '0;
                    end else begin
                        state_d = SETTLE;
                        mode_d  = pick_mode;
                        scnt_d  = '0;
                    end
                end
            end
            SETTLE: begin
                // Abort leaves mode at its new value; the next arbitration
                // may find it already matching.
                if (!req[owner_q]) begin
                    state_d = IDLE;
                end else if (scnt_q == SETTLE_LAST) begin
                    state_d = OWN;
                    gnt_d   = owner_onehot;
                    hcnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            OWN: begin
                // A voluntary release (rel or dropped req) takes priority
                // over the hold limit, so no timeout pulse in that case.
                if (rel[owner_q] || !req[owner_q] || hcnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + PW'(1);
                    tmo_d   = !(rel[owner_q] || !req[owner_q]);
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            mode_q  <= BW_MODE'(DEFAULT_MODE);
            owner_q <= '0;
            ptr_q   <= '0;
            scnt_q  <= '0;
            hcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            mode_q  <= mode_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            scnt_q  <= scnt_d;
            hcnt_q  <= hcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt         = gnt_q;
    assign mode        = mode_q;
    assign param_valid = (state_q == OWN);
    assign busy        = (state_q != IDLE);
    assign timeout     = tmo_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_param_mode_arbiter.sv
// Self-checking bench for param_mode_arbiter: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// behavioural model of ownership, settle time and hold time.
module tb_param_mode_arbiter;

    localparam int NREQ = 4;
    localparam int BW   = 2;
    localparam int SC   = 8;
    localparam int HM   = 64;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   req;
    logic [NREQ*BW-1:0] req_mode;
    logic [NREQ-1:0]   rel;
    logic [NREQ-1:0]   gnt;
    logic [BW-1:0]     mode;
    logic              param_valid;
    logic              busy;
    logic              timeout;
    logic [1:0]        state_dbg;

    always #5 clk = ~clk;

    param_mode_arbiter #(
        .NREQ(NREQ), .BW_MODE(BW), .SETTLE_CYC(SC), .HOLD_MAX(HM), .DEFAULT_MODE(0)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_mode(req_mode), .rel(rel),
        .gnt(gnt), .mode(mode), .param_valid(param_valid), .busy(busy),
        .timeout(timeout), .state_dbg(state_dbg)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    // Who owns the resource, whether still waiting for mode to settle,
    // cycles of settle left, cycles the grant has been visible.
    int          m_owner;
    bit          m_owning;
    bit          m_settling;
    int          m_left;
    int          m_held;
    int          m_ptr;
    logic [BW-1:0] m_mode;
    bit          m_timeout;

    logic [NREQ-1:0] exp_q[$];

    task automatic model_reset();
        m_owner = 0; m_owning = 0; m_settling = 0; m_left = 0;
        m_held = 0; m_ptr = 0; m_mode = '0; m_timeout = 0;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge
    task automatic model_step();
        int w;
        m_timeout = 0;
        if (m_owning) begin
            m_held++;
            if (rel[m_owner] || !req[m_owner] || m_held == HM) begin
                m_timeout = (m_held == HM) && rel[m_owner] == 1'b0 && req[m_owner] == 1'b1;
                m_owning  = 0;
                m_ptr     = (m_owner + 1) % NREQ;
            end
        end else if (m_settling) begin
            if (!req[m_owner]) begin
                m_settling = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_settling = 0;
                    m_owning   = 1;
                    m_held     = 0;
                end
            end
        end else if (req != '0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            m_owner = w;
            if (req_mode[w*BW +: BW] == m_mode || SC == 0) begin
                m_owning = 1;
                m_held   = 0;
            end else begin
                m_mode     = req_mode[w*BW +: BW];
                m_settling = 1;
                m_left     = SC;
            end
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [NREQ-1:0] eg;
        eg = m_owning ? (NREQ'(1) << m_owner) : '0;
        check("gnt",         32'(gnt),         32'(eg));
        check("mode",        32'(mode),        32'(m_mode));
        check("param_valid", 32'(param_valid), 32'(m_owning));
        check("busy",        32'(busy),        32'(m_owning || m_settling));
        check("timeout",     32'(timeout),     32'(m_timeout));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; req = '0; rel = '0; req_mode = '0;
        #1;
        model_reset();
        compare_model();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int gcount;
        int tcount;
        int seen1;
        rstn = 1'b0; req = '0; rel = '0; req_mode = '0;
        model_reset();

        // 1: reset values, then same-mode grant one cycle later
        do_reset();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        req = 4'b0001;
        cycle();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_mode", 32'(mode), 32'h0);
        check("t1_pv", 32'(param_valid), 32'h1);

        // 2: mode change to 3, grant exactly SC cycles after mode updates
        do_reset();
        req = 4'b0010; req_mode = 8'b0000_1100;
        cycle();
        check("t2_mode", 32'(mode), 32'h3);
        check("t2_gnt0", 32'(gnt), 32'h0);
        for (int i = 1; i < SC; i++) begin
            cycle();
            check("t2_pv_settle", 32'(param_valid), 32'h0);
        end
        cycle();
        check("t2_gnt", 32'(gnt), 32'h2);

        // 3: all requesting with immediate release rotate 0,1,2,3,0
        do_reset();
        req = 4'hF; rel = 4'hF;
        exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int c = 1; c <= 9; c++) begin
            cycle();
            if (c % 2 == 1) begin
                if (exp_q.size() > 0) check("t3_rot", 32'(gnt), 32'(exp_q.pop_front()));
                else check("t3_extra", 32'(gnt), 32'h0);
            end else begin
                check("t3_gap", 32'(gnt), 32'h0);
            end
        end
        check("t3_left", 32'(exp_q.size()), 32'h0);

        // 4: hold without release: HM cycles of grant, one timeout, next owner
        do_reset();
        req = 4'b0011; rel = '0;
        gcount = 0; tcount = 0; seen1 = 0;
        for (int c = 0; c < HM + 10 && seen1 == 0; c++) begin
            cycle();
            if (gnt == 4'b0001) gcount++;
            if (timeout) tcount++;
            if (gnt == 4'b0010) seen1 = 1;
        end
        check("t4_hold_len", 32'(gcount), 32'(HM));
        check("t4_timeouts", 32'(tcount), 32'h1);
        check("t4_next", 32'(seen1), 32'h1);

        // 5: non-owner rel ignored; owner rel on the limit edge is a plain release
        for (int c = 1; c < HM; c++) begin
            rel = (c < 5) ? 4'b1101 : 4'b0000;
            cycle();
            if (c < 5) check("t5_nonowner", 32'(gnt), 32'h2);
        end
        rel = 4'b0010;
        cycle();
        check("t5_rel_gnt", 32'(gnt), 32'h0);
        check("t5_no_tmo", 32'(timeout), 32'h0);
        rel = '0; req = '0;
        cycle();

        // 6: asynchronous reset mid-SETTLE restores outputs immediately
        do_reset();
        req = 4'b0100; req_mode = 8'b0010_0000;
        cycle();
        check("t6_mode2", 32'(mode), 32'h2);
        repeat (3) cycle();
        #2;
        rstn = 1'b0;
        #1;
        check("t6_mode", 32'(mode), 32'h0);
        check("t6_gnt", 32'(gnt), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1; req = '0;

        // Random run: sticky requests, changing modes, sparse releases
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 29) == 0) req[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end
                if ($urandom_range(0, 7) == 0) req_mode[i*BW +: BW] = BW'($urandom_range(0, 3));
                rel[i] = ($urandom_range(0, 39) == 0);
            end
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
